// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the multi-channel integer clock divider.
//   RATIO_W_DEF   : default ratio width per channel (max ratio 2**RATIO_W-1)
//   ratio_t       : ratio type at the default width
//   BYPASS_RATIO  : active ratio value meaning "output follows the reference"
//   MIN_DIV_RATIO : smallest ratio that actually divides
//   chan_mode_e   : decoded channel mode (bypass / dividing)
// -----------------------------------------------------------------------------
package clk_div_pkg;

  localparam int RATIO_W_DEF   = 8;
  localparam int BYPASS_RATIO  = 0;
  localparam int MIN_DIV_RATIO = 2;

  typedef logic [RATIO_W_DEF-1:0] ratio_t;

  typedef enum logic {
    MODE_BYPASS = 1'b0,
    MODE_DIVIDE = 1'b1
  } chan_mode_e;

endpackage

// File: rtl/clk_div_chan.sv
// -----------------------------------------------------------------------------
// clk_div_chan
// One divider channel: period counter, registered divided clock, shadow ratio,
// rising-edge tick and the bypass mux onto the reference clock.
//
// Ports
//   clk_i          in   reference clock
//   rst_ni         in   asynchronous active-low reset
//   en_i           in   divide enable
//   ratio_i        in   requested ratio (values below 2 mean bypass)
//   div_clk_o      out  divided clock, or clk_i while bypassed
//   tick_o         out  one-cycle pulse in the cycle the divided clock rises
//   active_ratio_o out  ratio currently in effect (0 = bypass)
//
// Build option CLK_DIV_DUTY50_EN: when defined, odd ratios get an exact 50%
// duty cycle through a negedge flop that stretches the high phase by half a
// reference cycle. Otherwise odd ratios are high ceil(N/2), low floor(N/2).
// -----------------------------------------------------------------------------
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int RATIO_W = RATIO_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [RATIO_W-1:0] ratio_i,
  output logic               div_clk_o,
  output logic               tick_o,
  output logic [RATIO_W-1:0] active_ratio_o
);

  localparam logic [RATIO_W-1:0] RATIO_BYPASS = RATIO_W'(BYPASS_RATIO);
  localparam logic [RATIO_W-1:0] RATIO_MIN    = RATIO_W'(MIN_DIV_RATIO);
  localparam logic [RATIO_W-1:0] ONE          = RATIO_W'(1);

  // Number of counter values for which div_q is high. Kept at RATIO_W bits:
  // (n >> 1) + n[0] is at most 2**(RATIO_W-1), so it cannot overflow.
  function automatic logic [RATIO_W-1:0] high_len(input logic [RATIO_W-1:0] n);
`ifdef CLK_DIV_DUTY50_EN
    // The negedge flop adds the missing half cycle on odd ratios.
    high_len = n >> 1;
`else
    high_len = (n >> 1) + RATIO_W'(n[0]);
`endif
  endfunction

  logic [RATIO_W-1:0] act_ratio_q, act_ratio_d;
  logic [RATIO_W-1:0] cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               tick_q, tick_d;
  logic               req_valid;
  logic [RATIO_W-1:0] req_ratio;
  logic               at_boundary;
  logic               div_shaped;
  chan_mode_e         mode;

  assign req_valid   = en_i && (ratio_i >= RATIO_MIN);
  assign req_ratio   = req_valid ? ratio_i : RATIO_BYPASS;
  assign mode        = (act_ratio_q == RATIO_BYPASS) ? MODE_BYPASS : MODE_DIVIDE;
  assign at_boundary = (mode == MODE_DIVIDE) && (cnt_q == act_ratio_q - ONE);

  // The request is only looked at while bypassed or on the last count of a
  // period, so a ratio or enable change can never truncate a divided period.
  always_comb begin
    act_ratio_d = act_ratio_q;
    cnt_d       = cnt_q + ONE;
    tick_d      = 1'b0;
    div_d       = 1'b1;
    if ((mode == MODE_BYPASS) || at_boundary) begin
      act_ratio_d = req_ratio;
      cnt_d       = '0;
      tick_d      = req_valid;
    end
    if (act_ratio_d != RATIO_BYPASS) begin
      div_d = (cnt_d < high_len(act_ratio_d));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_ratio_q <= RATIO_BYPASS;
      cnt_q       <= '0;
      div_q       <= 1'b1;
      tick_q      <= 1'b0;
    end else begin
      act_ratio_q <= act_ratio_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      tick_q      <= tick_d;
    end
  end

`ifdef CLK_DIV_DUTY50_EN
  // Half-cycle delayed copy of div_q, only for odd ratios. ORing it in moves
  // the falling edge half a reference cycle later; the two flops never toggle
  // on the same edge, so the OR cannot glitch.
  logic div_neg_q;

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_neg_q <= 1'b0;
    end else begin
      div_neg_q <= div_q & act_ratio_q[0];
    end
  end

  assign div_shaped = div_q | div_neg_q;
`else
  assign div_shaped = div_q;
`endif

  // Leaving bypass happens at a posedge (reference high, div_q loads 1) and
  // entering bypass happens at the end of a low phase (div_q low, reference
  // rising), so the mux switch never produces a runt pulse.
  assign div_clk_o      = (mode == MODE_BYPASS) ? clk_i : div_shaped;
  assign tick_o         = tick_q;
  assign active_ratio_o = act_ratio_q;

endmodule

// File: rtl/clk_divider_mc.sv
// -----------------------------------------------------------------------------
// clk_divider_mc
// Multi-channel programmable integer clock divider. NUM_CH independent
// channels are derived from one reference clock; each has its own ratio,
// enable and bypass. Ratio/enable changes are applied only at a divided
// period boundary.
//
// Ports
//   i_ref_clk       in   reference clock
//   i_rst_clk       in   asynchronous active-low reset
//   i_clk_en        in   per-channel divide enable            [NUM_CH]
//   i_div_ratio     in   per-channel requested ratio          [NUM_CH*RATIO_W]
//   o_div_clk       out  per-channel divided clock            [NUM_CH]
//   o_tick          out  per-channel divided rising-edge tick [NUM_CH]
//   o_active_ratio  out  per-channel ratio in effect, 0=bypass [NUM_CH*RATIO_W]
//
// Channel c uses bits [c*RATIO_W +: RATIO_W] of the ratio buses.
// Build option CLK_DIV_DUTY50_EN selects exact 50% duty for odd ratios.
// -----------------------------------------------------------------------------
module clk_divider_mc
  import clk_div_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int RATIO_W = RATIO_W_DEF
) (
  input  logic                      i_ref_clk,
  input  logic                      i_rst_clk,
  input  logic [NUM_CH-1:0]         i_clk_en,
  input  logic [NUM_CH*RATIO_W-1:0] i_div_ratio,
  output logic [NUM_CH-1:0]         o_div_clk,
  output logic [NUM_CH-1:0]         o_tick,
  output logic [NUM_CH*RATIO_W-1:0] o_active_ratio
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    clk_div_chan #(
      .RATIO_W (RATIO_W)
    ) u_chan (
      .clk_i          (i_ref_clk),
      .rst_ni         (i_rst_clk),
      .en_i           (i_clk_en[c]),
      .ratio_i        (i_div_ratio[c*RATIO_W +: RATIO_W]),
      .div_clk_o      (o_div_clk[c]),
      .tick_o         (o_tick[c]),
      .active_ratio_o (o_active_ratio[c*RATIO_W +: RATIO_W])
    );
  end

endmodule

// File: tb/tb_clk_divider_mc.sv
// -----------------------------------------------------------------------------
// tb_clk_divider_mc
// Directed bench for clk_divider_mc. Each reference cycle the expected
// per-channel outputs are pushed to a scoreboard queue before the edge and
// popped/compared 1 time unit after it. Directed period / high-time / latency
// checks are layered on top.
// -----------------------------------------------------------------------------
module tb_clk_divider_mc;

  localparam int NUM_CH = 2;
  localparam int RW     = 8;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_CH-1:0]    en;
  logic [NUM_CH*RW-1:0] ratio;
  logic [NUM_CH-1:0]    div_clk;
  logic [NUM_CH-1:0]    tick;
  logic [NUM_CH*RW-1:0] act;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int   ch;
    logic dclk;
    logic tk;
    int   ar;
  } exp_t;

  exp_t sbq[$];

  // Reference model state: ratio in effect and position within the period.
  int   mact  [NUM_CH];
  int   mcnt  [NUM_CH];
  logic mtick [NUM_CH];

  clk_divider_mc #(
    .NUM_CH  (NUM_CH),
    .RATIO_W (RW)
  ) dut (
    .i_ref_clk      (clk),
    .i_rst_clk      (rst_n),
    .i_clk_en       (en),
    .i_div_ratio    (ratio),
    .o_div_clk      (div_clk),
    .o_tick         (tick),
    .o_active_ratio (act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      mact[c]  = 0;
      mcnt[c]  = 0;
      mtick[c] = 1'b0;
    end
  endfunction

  // Advance the model by one reference posedge using the current inputs.
  function automatic void model_edge();
    int r;
    bit valid;
    for (int c = 0; c < NUM_CH; c++) begin
      r     = int'(ratio[c*RW +: RW]);
      valid = en[c] && (r >= 2);
      if (mact[c] == 0 || mcnt[c] == mact[c] - 1) begin
        mact[c]  = valid ? r : 0;
        mcnt[c]  = 0;
        mtick[c] = valid;
      end else begin
        mcnt[c]  = mcnt[c] + 1;
        mtick[c] = 1'b0;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One reference cycle: predict, push, clock, pop and compare.
  task automatic step();
    exp_t e;
    model_edge();
    for (int c = 0; c < NUM_CH; c++) begin
      e.ch   = c;
      // At posedge+1 a bypassed output shows the (high) reference clock.
      e.dclk = (mact[c] == 0) ? 1'b1 : (mcnt[c] < (mact[c] + 1) / 2);
      e.tk   = mtick[c];
      e.ar   = mact[c];
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      assert (div_clk[e.ch] === e.dclk)
      else begin
        failures++;
        $error("FAIL div_clk ch%0d got=%b exp=%b", e.ch, div_clk[e.ch], e.dclk);
      end
      checks++;
      assert (tick[e.ch] === e.tk)
      else begin
        failures++;
        $error("FAIL tick ch%0d got=%b exp=%b", e.ch, tick[e.ch], e.tk);
      end
      checks++;
      assert (act[e.ch*RW +: RW] === RW'(e.ar))
      else begin
        failures++;
        $error("FAIL active_ratio ch%0d got=%0d exp=%0d", e.ch, act[e.ch*RW +: RW], e.ar);
      end
    end
  endtask

  // Step until the channel ticks; an expired budget counts as a failure.
  task automatic align_tick(input int ch, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (tick[ch] === 1'b1) seen = 1'b1;
    end
    chk($sformatf("align_tick ch%0d", ch), 32'(seen), 32'd1);
  endtask

  // Measure one full divided period (tick to tick) and its high time.
  task automatic measure(input int ch, input int exp_per, input int exp_high);
    int  n;
    int  hi;
    bit  seen;
    align_tick(ch, 600);
    n    = 0;
    hi   = 0;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      if (div_clk[ch] === 1'b1) hi++;
      n++;
      step();
      if (tick[ch] === 1'b1) seen = 1'b1;
    end
    chk($sformatf("period ch%0d", ch), 32'(n), 32'(exp_per));
    chk($sformatf("high_time ch%0d", ch), 32'(hi), 32'(exp_high));
  endtask

  initial begin
    int n;
    bit done;
    rst_n = 1'b0;
    en    = '0;
    ratio = '0;
    model_reset();

    // Reset state: bypass, reference passes straight through.
    #2;
    chk("reset act", 32'(act), 32'd0);
    chk("reset tick", 32'(tick), 32'd0);
    chk("reset div_clk low", 32'(div_clk), 32'(clk ? 2'b11 : 2'b00));
    @(posedge clk);
    #1;
    chk("reset div_clk high", 32'(div_clk), 32'b11);
    rst_n = 1'b1;
    repeat (3) step();

    // 1) ratio 4 on ch0: load after one cycle, period 4, 2 high / 2 low.
    en[0]        = 1'b1;
    ratio[7:0]   = 8'd4;
    step();
    chk("load act ch0", 32'(act[7:0]), 32'd4);
    chk("load tick ch0", 32'(tick[0]), 32'd1);
    repeat (6) step();
    measure(0, 4, 2);

    // 2) ratio 5: 3 high / 2 low at posedge sampling; mid-cycle of cnt=2
    //    distinguishes the two duty-cycle builds.
    ratio[7:0] = 8'd5;
    measure(0, 5, 3);
    align_tick(0, 20);
    step();
    step();
    @(negedge clk);
    #1;
`ifdef CLK_DIV_DUTY50_EN
    chk("odd duty negedge ch0", 32'(div_clk[0]), 32'd0);
`else
    chk("odd duty negedge ch0", 32'(div_clk[0]), 32'd1);
`endif

    // 3) ratio 4 -> 6 requested at cnt=1: current period still ends at 4.
    ratio[7:0] = 8'd4;
    align_tick(0, 20);
    align_tick(0, 20);
    step();
    ratio[7:0] = 8'd6;
    n    = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      n++;
      if (tick[0] === 1'b1) done = 1'b1;
    end
    chk("4->6 remaining cycles", 32'(n), 32'd3);
    measure(0, 6, 3);

    // 4) bypass requests: ratio 1, ratio 0, en 0.
    step();
    ratio[7:0] = 8'd1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      if (act[7:0] === 8'd0) done = 1'b1;
    end
    chk("ratio1 enters bypass", 32'(done), 32'd1);
    @(negedge clk);
    #1;
    chk("bypass follows ref low", 32'(div_clk[0]), 32'd0);
    chk("bypass tick", 32'(tick[0]), 32'd0);
    repeat (3) step();
    ratio[7:0] = 8'd0;
    repeat (3) step();
    en[0]      = 1'b0;
    ratio[7:0] = 8'd4;
    repeat (3) step();
    // en drops at cnt=1: bypass only after cnt reaches 3.
    en[0] = 1'b1;
    align_tick(0, 20);
    step();
    en[0] = 1'b0;
    n    = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      n++;
      if (act[7:0] === 8'd0) done = 1'b1;
    end
    chk("en drop cycles to bypass", 32'(n), 32'd3);

    // 5) independent channels, then max ratio on ch1.
    en         = 2'b11;
    ratio[7:0] = 8'd3;
    ratio[15:8] = 8'd8;
    measure(0, 3, 2);
    measure(1, 8, 4);
    ratio[15:8] = 8'd255;
    measure(1, 255, 128);

    // 6) async reset at cnt=2 of ratio 6, then reload.
    ratio[7:0] = 8'd6;
    align_tick(0, 20);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst act", 32'(act), 32'd0);
    chk("async rst tick", 32'(tick), 32'd0);
    chk("async rst div_clk", 32'(div_clk), 32'(clk ? 2'b11 : 2'b00));
    model_reset();
    @(negedge clk);
    #1;
    chk("in rst div_clk ref low", 32'(div_clk), 32'b00);
    rst_n = 1'b1;
    step();
    chk("reload tick ch0", 32'(tick[0]), 32'd1);
    chk("reload act ch0", 32'(act[7:0]), 32'd6);
    measure(0, 6, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
